xmega_reg_file: RTL
===================

// Module: xmega_reg_file
// PURPOSE
//  Operand/result end of the ALU interface: 32x8 general-purpose register file plus SREG.
//  Supplies rs1/rs2 by address, commits rd at rda, and holds SREG for ALU read-back.
//  Also updates the X/Y/Z pointers for LD/ST, and gives the data bus access to R0-R31 at
//  data-space 0x00-0x1F. Sits between the decoder/ALU and the memory stage of the XMEGA core.
// PARAMETERS
//  CORE_TYPE  `MEGA_XMEGA_1  core variant; same encoding as the rest of the core
//  BYPASS     1              1: reads of a register written this cycle return new data; 0: old data
// PORTS
//  clk        in   1   core clock; all state updates on rising edge
//  rst        in   1   synchronous reset, active-high
//  rs1a       in   5   operand 1 register address
//  rs1_wide   in   1   1: rs1 = {R[rs1a|1], R[rs1a&~1]}; 0: rs1 = {8'h00, R[rs1a]}
//  rs1        out  16  operand 1 to ALU
//  rs2a       in   5   operand 2 register address
//  rs2_wide   in   1   as rs1_wide, for rs2
//  rs2        out  16  operand 2 to ALU
//  rda        in   5   result register address
//  rd         in   16  ALU result
//  rd_wr      in   1   commit rd at the rising edge
//  rd_wide    in   1   1: write the pair R[rda&~1] = rd[7:0], R[rda|1] = rd[15:8]; 0: R[rda] = rd[7:0]
//  sreg_in    in   8   SREG from ALU
//  sreg_wr    in   1   commit sreg_in
//  sreg       out  8   current SREG to ALU/branch unit
//  ptr_sel    in   2   pointer select: 0 none, 1 X (R27:R26), 2 Y (R29:R28), 3 Z (R31:R30)
//  ptr_op     in   2   pointer op: 0 hold, 1 post-increment, 2 pre-decrement, 3 hold
//  ptr        out  16  effective address of the selected pointer
//  ds_addr    in   5   data-space register address
//  ds_wr      in   1   data-space byte write
//  ds_wdata   in   8   data-space write data
//  ds_rdata   out  8   R[ds_addr], subject to the same bypass rule as rs1/rs2
// BEHAVIOUR
//  - Reset: R0-R31 = 8'h00 and SREG = 8'h00 at the first rising edge with rst = 1.
//    While rst = 1 all writes are ignored. Outputs are combinational views of this state.
//  - Read latency 0 (combinational). Write latency 1: a write is visible in the array after the edge.
//  - Bypass (BYPASS = 1), per port:
//    - The returned byte is the one being written this cycle, chosen by the write priority below.
//    - A wide write covers both bytes of its pair; a narrow write covers only its own byte.
//  - Write priority on a per-byte address collision: rd_wr > ds_wr > pointer update.
//    The losing writes to that byte are dropped; non-colliding bytes still commit.
//  - Wide addressing: bit 0 of rda/rs1a/rs2a is ignored when the matching *_wide = 1.
//  - SREG: sreg <= sreg_in when sreg_wr = 1, otherwise it holds. sreg never bypasses;
//    the ALU always sees the registered value.
//  - Pointer logic (ptr_sel != 0):
//    - P = current pair value.
//    - op 1: ptr = P, P <= P + 1.
//    - op 2: ptr = P - 1, P <= P - 1.
//    - op 0/3: ptr = P, no update.
//    - Arithmetic is 16-bit modulo: 16'hFFFF + 1 -> 16'h0000; 16'h0000 - 1 -> 16'hFFFF.
//  - When ptr_sel = 0, ptr = 16'h0000 and no update occurs.
//  - Simultaneous rd_wr to one byte of the selected pointer pair: rd wins on that byte.
//    The other byte takes the pointer result.
//  - Reset mid-operation: every pending write in that cycle is discarded; the state is the reset state.
// STRUCTURE
//  - Flag indices (`XMEGA_FLAG_*), CORE_TYPE encodings, and the new `XMEGA_PTR_X/Y/Z and
//    `XMEGA_PTR_OP_* codes go in the shared header xmega_v.v.
//  - One sub-module, xmega_ptr_unit: combinational pointer select plus +/-1 adder, producing
//    ptr, the next pair value, and the pair's byte write enables.
//  - The array, write arbitration and bypass muxes stay in xmega_reg_file.
// TESTING
//  1. Reset: write R5 = 8'hAA, assert rst for one cycle, read rs1a = 5 -> rs1 = 16'h0000, sreg = 8'h00.
//  2. Wide write/read: rd_wr, rd_wide, rda = 25, rd = 16'h1234.
//     Next cycle rs1a = 24, rs1_wide = 1 -> 16'h1234; rs2a = 25, rs2_wide = 0 -> 16'h0012.
//  3. Bypass: same cycle rd_wr rda = 3, rd = 8'h5A, rs2a = 3 -> rs2 = 16'h005A with BYPASS = 1;
//     with BYPASS = 0 -> the old value.
//  4. Pointer wrap: Z = 16'hFFFF, ptr_sel = 3, ptr_op = 1 -> ptr = 16'hFFFF, then Z = 16'h0000.
//     X = 16'h0000, ptr_op = 2 -> ptr = 16'hFFFF, then X = 16'hFFFF.
//  5. Collision: Y = 16'h0100, ptr_op = 1, with rd_wr rda = 28, rd = 8'h77 in the same cycle
//     -> R28 = 8'h77, R29 = 8'h01. Also ds_wr and rd_wr to R7 together -> R7 = rd.
//  6. SREG: sreg_in = 8'h83, sreg_wr = 1 -> sreg = 8'h83 next cycle and not in the same cycle;
//     sreg_wr = 0 -> sreg holds.

Source files
------------

// File: rtl/xmega_reg_file_pkg.sv
// ============================================================================
//  Module : xmega_reg_file_pkg
//  Brief  : Shared encodings for the XMEGA register file and pointer unit.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package xmega_reg_file_pkg;

  // Core variant encodings
  localparam int CORE_MEGA_XMEGA_1 = 1;
  localparam int CORE_MEGA_XMEGA_2 = 2;

  // SREG flag bit positions
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;
  localparam int FLAG_S = 4;
  localparam int FLAG_H = 5;
  localparam int FLAG_T = 6;
  localparam int FLAG_I = 7;

  typedef enum logic [1:0] {
    PTR_NONE = 2'd0,
    PTR_X    = 2'd1,
    PTR_Y    = 2'd2,
    PTR_Z    = 2'd3
  } ptr_sel_e;

  typedef enum logic [1:0] {
    PTR_OP_HOLD  = 2'd0,
    PTR_OP_INC   = 2'd1,
    PTR_OP_DEC   = 2'd2,
    PTR_OP_HOLD2 = 2'd3
  } ptr_op_e;

  // Low register of each pointer pair: X = R26, Y = R28, Z = R30
  localparam logic [4:0] PTR_X_LO = 5'd26;
  localparam logic [4:0] PTR_Y_LO = 5'd28;
  localparam logic [4:0] PTR_Z_LO = 5'd30;

  function automatic bit core_valid(input int core_type);
    return (core_type == CORE_MEGA_XMEGA_1) || (core_type == CORE_MEGA_XMEGA_2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/xmega_reg_file_if.sv
// ============================================================================
//  Module : xmega_reg_file_if
//  Brief  : Operand, result, SREG, pointer and data-space ports of the register file.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

interface xmega_reg_file_if;
  logic [4:0]  rs1a;
  logic        rs1_wide;
  logic [15:0] rs1;
  logic [4:0]  rs2a;
  logic        rs2_wide;
  logic [15:0] rs2;
  logic [4:0]  rda;
  logic [15:0] rd;
  logic        rd_wr;
  logic        rd_wide;
  logic [7:0]  sreg_in;
  logic        sreg_wr;
  logic [7:0]  sreg;
  logic [1:0]  ptr_sel;
  logic [1:0]  ptr_op;
  logic [15:0] ptr;
  logic [4:0]  ds_addr;
  logic        ds_wr;
  logic [7:0]  ds_wdata;
  logic [7:0]  ds_rdata;

  modport master (
    output rs1a, rs1_wide, rs2a, rs2_wide, rda, rd, rd_wr, rd_wide,
           sreg_in, sreg_wr, ptr_sel, ptr_op, ds_addr, ds_wr, ds_wdata,
    input  rs1, rs2, sreg, ptr, ds_rdata
  );

  modport slave (
    input  rs1a, rs1_wide, rs2a, rs2_wide, rda, rd, rd_wr, rd_wide,
           sreg_in, sreg_wr, ptr_sel, ptr_op, ds_addr, ds_wr, ds_wdata,
    output rs1, rs2, sreg, ptr, ds_rdata
  );
endinterface

`default_nettype wire

// File: rtl/xmega_ptr_unit.sv
// ============================================================================
//  Module : xmega_ptr_unit
//  Brief  : X/Y/Z pointer select with post-increment / pre-decrement adder.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module xmega_ptr_unit
  import xmega_reg_file_pkg::*;
(
  input  logic [1:0]  sel,
  input  logic [1:0]  op,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  output logic [15:0] ptr,
  output logic [15:0] ptr_next,
  output logic [4:0]  pair_lo,
  output logic [1:0]  pair_we
);

  logic [15:0] w_cur;

  always_comb begin
    w_cur    = 16'h0000;
    pair_lo  = PTR_X_LO;
    ptr      = 16'h0000;
    ptr_next = 16'h0000;
    pair_we  = 2'b00;
    case (ptr_sel_e'(sel))
      PTR_X:   begin w_cur = x; pair_lo = PTR_X_LO; end
      PTR_Y:   begin w_cur = y; pair_lo = PTR_Y_LO; end
      PTR_Z:   begin w_cur = z; pair_lo = PTR_Z_LO; end
      default: begin w_cur = 16'h0000; pair_lo = PTR_X_LO; end
    endcase
    if (ptr_sel_e'(sel) != PTR_NONE) begin
      ptr      = w_cur;
      ptr_next = w_cur;
      case (ptr_op_e'(op))
        PTR_OP_INC: begin
          ptr_next = w_cur + 16'd1;
          pair_we  = 2'b11;
        end
        PTR_OP_DEC: begin
          // Pre-decrement: the access address is the decremented value
          ptr_next = w_cur - 16'd1;
          ptr      = ptr_next;
          pair_we  = 2'b11;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/xmega_reg_file.sv
// ============================================================================
//  Module : xmega_reg_file
//  Brief  : 32x8 register file with SREG, pointer update and data-space access.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module xmega_reg_file
  import xmega_reg_file_pkg::*;
#(
  parameter int CORE_TYPE = CORE_MEGA_XMEGA_1,
  parameter bit BYPASS    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  xmega_reg_file_if.slave   bus
);

  localparam bit PTR_EN = core_valid(CORE_TYPE);

  logic [7:0]  r_regs [32];
  logic [7:0]  r_sreg;
  logic [7:0]  w_wd   [32];
  logic [7:0]  w_view [32];
  logic        w_we   [32];
  logic [15:0] w_ptr;
  logic [15:0] w_ptr_next;
  logic [4:0]  w_pair_lo;
  logic [1:0]  w_pair_we;
  logic [4:0]  w_rd_lo;
  logic [4:0]  w_rd_hi;

  xmega_ptr_unit u_ptr (
    .sel      (bus.ptr_sel),
    .op       (bus.ptr_op),
    .x        ({r_regs[27], r_regs[26]}),
    .y        ({r_regs[29], r_regs[28]}),
    .z        ({r_regs[31], r_regs[30]}),
    .ptr      (w_ptr),
    .ptr_next (w_ptr_next),
    .pair_lo  (w_pair_lo),
    .pair_we  (w_pair_we)
  );

  assign w_rd_lo = bus.rd_wide ? {bus.rda[4:1], 1'b0} : bus.rda;
  assign w_rd_hi = {bus.rda[4:1], 1'b1};

  // Later assignments override earlier ones: pointer < data space < rd
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      w_we[i] = 1'b0;
      w_wd[i] = r_regs[i];
      if (PTR_EN && w_pair_we[0] && (w_pair_lo == 5'(i))) begin
        w_we[i] = 1'b1;
        w_wd[i] = w_ptr_next[7:0];
      end
      if (PTR_EN && w_pair_we[1] && ({w_pair_lo[4:1], 1'b1} == 5'(i))) begin
        w_we[i] = 1'b1;
        w_wd[i] = w_ptr_next[15:8];
      end
      if (bus.ds_wr && (bus.ds_addr == 5'(i))) begin
        w_we[i] = 1'b1;
        w_wd[i] = bus.ds_wdata;
      end
      if (bus.rd_wr && (w_rd_lo == 5'(i))) begin
        w_we[i] = 1'b1;
        w_wd[i] = bus.rd[7:0];
      end
      if (bus.rd_wr && bus.rd_wide && (w_rd_hi == 5'(i))) begin
        w_we[i] = 1'b1;
        w_wd[i] = bus.rd[15:8];
      end
      if (rst) begin
        w_we[i] = 1'b0;
      end
      w_view[i] = (BYPASS && w_we[i]) ? w_wd[i] : r_regs[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 8'h00;
      end
      r_sreg <= 8'h00;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (w_we[i]) begin
          r_regs[i] <= w_wd[i];
        end
      end
      if (bus.sreg_wr) begin
        r_sreg <= bus.sreg_in;
      end
    end
  end

  assign bus.rs1 = bus.rs1_wide ? {w_view[{bus.rs1a[4:1], 1'b1}], w_view[{bus.rs1a[4:1], 1'b0}]}
                                : {8'h00, w_view[bus.rs1a]};
  assign bus.rs2 = bus.rs2_wide ? {w_view[{bus.rs2a[4:1], 1'b1}], w_view[{bus.rs2a[4:1], 1'b0}]}
                                : {8'h00, w_view[bus.rs2a]};
  assign bus.ds_rdata = w_view[bus.ds_addr];
  assign bus.ptr      = PTR_EN ? w_ptr : 16'h0000;
  assign bus.sreg     = r_sreg;

endmodule

`default_nettype wire
